// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline control path: hazard FSM states, the bundled
// stage-control word and a saturating increment used by the perf counters.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        FLUSH = 2'd2
    } hazard_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic pc_redirect;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } hazard_ctrl_t;

    localparam int PERF_CNT_W = 64;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three saturating 64-bit event counters for hazard_ctrl; present only in
// builds with HAZARD_PERF_EN defined.
module hazard_perf_cnt
    import pipeline_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_stall,
    input  logic                  inc_dwait,
    input  logic                  inc_flush,
    output logic [PERF_CNT_W-1:0] perf_stall_cycles,
    output logic [PERF_CNT_W-1:0] perf_dwait_cycles,
    output logic [PERF_CNT_W-1:0] perf_flush_count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_dwait_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (inc_stall) perf_stall_cycles <= sat_inc(perf_stall_cycles);
            if (inc_dwait) perf_dwait_cycles <= sat_inc(perf_dwait_cycles);
            if (inc_flush) perf_flush_count  <= sat_inc(perf_flush_count);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirects and dmem waits.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_en,
    input  logic                 id_rs2_en,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_reg_wen,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 pc_redirect,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_flush,
`ifdef HAZARD_PERF_EN
    output logic [63:0]          perf_stall_cycles,
    output logic [63:0]          perf_dwait_cycles,
    output logic [63:0]          perf_flush_count,
`endif
    output logic [1:0]           state_o
);

    hazard_state_e state_q, state_d;
    hazard_ctrl_t  ctrl;
    logic          rst_d1;
    logic          blank;
    logic          freeze;
    logic          load_use;

    // The pipeline is held blank for the reset cycle and the one after it.
    always_ff @(posedge clk) begin
        rst_d1 <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    assign blank    = rst | rst_d1;
    assign freeze   = mem_req & ~mem_ready;
    assign load_use = ex_mem_read & ex_reg_wen & (ex_rd != '0) &
                      ((id_rs1_en & (id_rs1 == ex_rd)) | (id_rs2_en & (id_rs2 == ex_rd)));

    always_comb begin
        ctrl    = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                    memwb_en: 1'b1, default: 1'b0};
        state_d = RUN;
        if (blank) begin
            ctrl = '{pc_redirect: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1,
                     memwb_flush: 1'b1, default: 1'b0};
        end else if (freeze) begin
            // EX is frozen, so redirect/load-use are re-evaluated after the wait.
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_en     = 1'b0;
            ctrl.exmem_en    = 1'b0;
            ctrl.memwb_flush = 1'b1;
            state_d          = (state_q == FLUSH) ? FLUSH : DWAIT;
        end else if (ex_redirect) begin
            ctrl.pc_redirect = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            state_d          = FLUSH;
        end else if (state_q == FLUSH) begin
            // Kill the wrong-path word the synchronous imem returns this cycle.
            ctrl.ifid_flush = 1'b1;
        end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign memwb_en    = ctrl.memwb_en;
    assign pc_redirect = ctrl.pc_redirect;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign memwb_flush = ctrl.memwb_flush;
    assign state_o     = rst ? RUN : state_q;

`ifdef HAZARD_PERF_EN
    logic ev_stall, ev_dwait, ev_flush;

    assign ev_dwait = ~blank & freeze;
    assign ev_flush = ~blank & ~freeze & ex_redirect;
    assign ev_stall = ~blank & ~freeze & ~ex_redirect & (state_q != FLUSH) & load_use;

    hazard_perf_cnt u_perf (
        .clk               (clk),
        .rst               (rst),
        .inc_stall         (ev_stall),
        .inc_dwait         (ev_dwait),
        .inc_flush         (ev_flush),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_dwait_cycles (perf_dwait_cycles),
        .perf_flush_count  (perf_flush_count)
    );
`endif

endmodule
